// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/squash controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } ctrl_state_t;

  // Pipeline register write-enable polarity: a 1 holds the register.
  localparam logic REG_HOLD  = 1'b1;
  localparam logic REG_WRITE = 1'b0;

  // addi x0, x0, 0 -- the bubble the datapath loads on a squash.
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-field inputs and hold/squash/status outputs between datapath and controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             valid_id;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic             halt_id;
  logic             valid_ex;
  logic             load_ex;
  logic [4:0]       rd_ex;
  logic             redirect_ex;
  logic             mem_req_mem;
  logic             dmem_ready;
  logic             halt_wb;

  logic             pc_hold;
  logic             WEN_if_id;
  logic             WEN_id_ex;
  logic             WEN_ex_mem;
  logic             WEN_mem_wb;
  logic             squash_if_id;
  logic             squash_id_ex;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] squash_cnt;

  // Datapath side: supplies stage fields, obeys the controls.
  modport master (
    output valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id, halt_id,
           valid_ex, load_ex, rd_ex, redirect_ex, mem_req_mem, dmem_ready, halt_wb,
    input  pc_hold, WEN_if_id, WEN_id_ex, WEN_ex_mem, WEN_mem_wb,
           squash_if_id, squash_id_ex, halted, error, stall_cnt, squash_cnt
  );

  // Controller side.
  modport slave (
    input  valid_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id, halt_id,
           valid_ex, load_ex, rd_ex, redirect_ex, mem_req_mem, dmem_ready, halt_wb,
    output pc_hold, WEN_if_id, WEN_id_ex, WEN_ex_mem, WEN_mem_wb,
           squash_if_id, squash_id_ex, halted, error, stall_cnt, squash_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and data-memory-wait hazard detection.
module hazard_detect (
  input  logic       valid_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic       valid_ex,
  input  logic       load_ex,
  input  logic [4:0] rd_ex,
  input  logic       mem_req_mem,
  input  logic       dmem_ready,
  output logic       lu,
  output logic       mw
);

  // A load in EX feeding a source read in ID needs one bubble; x0 never creates a dependency.
  always_comb begin
    lu = valid_ex & load_ex & (rd_ex != 5'd0) & valid_id &
         ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
    mw = mem_req_mem & ~dmem_ready;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/squash sequencer for the 5-stage in-order pipeline.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              drain_q, drain_d;
  logic [CNT_W-1:0]  stall_cnt_q, squash_cnt_q;
  logic              lu, mw;

  logic pc_hold, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb;
  logic squash_if_id, squash_id_ex, halted, error;

  hazard_detect u_hazard_detect (
    .valid_id    (bus.valid_id),
    .rs1_id      (bus.rs1_id),
    .rs2_id      (bus.rs2_id),
    .rs1_used_id (bus.rs1_used_id),
    .rs2_used_id (bus.rs2_used_id),
    .valid_ex    (bus.valid_ex),
    .load_ex     (bus.load_ex),
    .rd_ex       (bus.rd_ex),
    .mem_req_mem (bus.mem_req_mem),
    .dmem_ready  (bus.dmem_ready),
    .lu          (lu),
    .mw          (mw)
  );

  // State, wait counter and drain flag advance on the falling edge together with the pipeline registers.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      wait_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
    end
  end

  // Next state: memory wait beats redirect beats halt handling; drain_q remembers to resume draining after a wait.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    case (state_q)
      RUN, DRAIN: begin
        if (mw) begin
          if (MEM_TIMEOUT <= 1) begin
            state_d = ERROR;
          end else begin
            state_d = MEM_WAIT;
          end
          wait_d  = WAIT_ONE;
          drain_d = (state_q == DRAIN);
        end else if (bus.redirect_ex) begin
          state_d = RUN;
          drain_d = 1'b0;
        end else if (bus.halt_wb) begin
          state_d = HALTED;
        end else if ((state_q == RUN) && bus.valid_id && bus.halt_id && !lu) begin
          // Only leave RUN once the halt actually advances out of ID, otherwise the drain squash would kill it.
          state_d = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          if (drain_q) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
          wait_d  = '0;
          drain_d = 1'b0;
        end else if ((wait_q + WAIT_ONE) >= WAIT_LIMIT) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Control outputs per state; everything is forced low while reset is asserted.
  always_comb begin
    pc_hold      = 1'b0;
    wen_if_id    = REG_WRITE;
    wen_id_ex    = REG_WRITE;
    wen_ex_mem   = REG_WRITE;
    wen_mem_wb   = REG_WRITE;
    squash_if_id = 1'b0;
    squash_id_ex = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    if (!RST) begin
      case (state_q)
        RUN, DRAIN: begin
          if (mw) begin
            pc_hold    = 1'b1;
            wen_if_id  = REG_HOLD;
            wen_id_ex  = REG_HOLD;
            wen_ex_mem = REG_HOLD;
            wen_mem_wb = REG_HOLD;
          end else if (bus.redirect_ex) begin
            squash_if_id = 1'b1;
            squash_id_ex = 1'b1;
          end else if (state_q == DRAIN) begin
            pc_hold      = 1'b1;
            squash_if_id = 1'b1;
          end else if (lu) begin
            pc_hold      = 1'b1;
            wen_if_id    = REG_HOLD;
            squash_id_ex = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            pc_hold    = 1'b1;
            wen_if_id  = REG_HOLD;
            wen_id_ex  = REG_HOLD;
            wen_ex_mem = REG_HOLD;
            wen_mem_wb = REG_HOLD;
          end
        end
        default: begin
          pc_hold    = 1'b1;
          wen_if_id  = REG_HOLD;
          wen_id_ex  = REG_HOLD;
          wen_ex_mem = REG_HOLD;
          wen_mem_wb = REG_HOLD;
          halted     = (state_q == HALTED);
          error      = (state_q != HALTED);
        end
      endcase
    end
  end

  // Saturating performance counters, frozen once the core has stopped.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (pc_hold && ((state_q == RUN) || (state_q == MEM_WAIT)) && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if ((squash_if_id || squash_id_ex) && (state_q != HALTED) && (state_q != ERROR) &&
          (squash_cnt_q != CNT_MAX)) begin
        squash_cnt_q <= squash_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.WEN_if_id    = wen_if_id;
  assign bus.WEN_id_ex    = wen_id_ex;
  assign bus.WEN_ex_mem   = wen_ex_mem;
  assign bus.WEN_mem_wb   = wen_mem_wb;
  assign bus.squash_if_id = squash_if_id;
  assign bus.squash_id_ex = squash_id_ex;
  assign bus.halted       = halted;
  assign bus.error        = error;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.squash_cnt   = squash_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/squash sequencer for the 5-stage in-order pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Detects load-use hazards, taken branch/jump redirects and multi-cycle data-memory accesses.
- Drives the per-register hold (WEN) and squash controls and the PC hold.
- Sequences the halt drain and exposes stall/squash performance counters.
- Sits beside the datapath in the CPU top level, fed by ID/EX/MEM/WB stage fields.

Parameters:
MEM_TIMEOUT, 64, max consecutive dmem-wait cycles before entering ERROR
CNT_W, 32, width of performance counters

Ports:
CLK  input  1  core clock; state and counters update on falling edge, coincident with pipeline registers
RST  input  1  asynchronous, active-high reset
valid_id  input  1  ID stage holds a valid instruction
rs1_id, rs2_id  input  5 each  source register indices in ID
rs1_used_id, rs2_used_id  input  1 each  source actually read by ID instruction
halt_id  input  1  ID instruction is a halt
valid_ex  input  1  EX stage valid
load_ex  input  1  EX instruction is a load
rd_ex  input  5  EX destination register
redirect_ex  input  1  taken branch or jump resolved in EX
mem_req_mem  input  1  valid load/store in MEM
dmem_ready  input  1  data memory completes the MEM access this cycle
halt_wb  input  1  halt has reached WB
pc_hold  output  1  1 = PC does not update
WEN_if_id, WEN_id_ex, WEN_ex_mem, WEN_mem_wb  output  1 each  1 = hold register (codebase convention: write when 0)
squash_if_id, squash_id_ex  output  1 each  insert NOP bubble into that register
halted  output  1  core stopped after clean halt
error  output  1  sticky dmem timeout
stall_cnt  output  CNT_W  cycles with pc_hold=1 while RUN/MEM_WAIT
squash_cnt  output  CNT_W  cycles with any squash asserted

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED, ERROR. Reset → RUN, all outputs 0, counters 0, wait counter 0.
- Hazard terms (combinational):
  - lu = valid_ex & load_ex & rd_ex≠0 & valid_id & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
  - mw = mem_req_mem & ~dmem_ready.
- Priority in RUN/DRAIN: mw > redirect_ex > lu > normal.
  - mw: all four WEN=1, pc_hold=1, no squash. Next state MEM_WAIT; wait counter=1.
  - redirect_ex: squash_if_id=1, squash_id_ex=1, all WEN=0, pc_hold=0 (PC takes target). Lasts exactly one cycle. A simultaneous lu is discarded.
  - lu: pc_hold=1, WEN_if_id=1, squash_id_ex=1, WEN_ex_mem=WEN_mem_wb=0. Exactly one bubble; lu deasserts next cycle because the load has moved to MEM.
  - normal: all 0.
- MEM_WAIT:
  - Outputs as in mw.
  - dmem_ready=1 → RUN (or DRAIN if drain flag set); outputs normal that cycle.
  - Otherwise the wait counter increments. Reaching MEM_TIMEOUT → ERROR.
- DRAIN:
  - Entered from RUN when valid_id & halt_id and no mw/redirect.
  - pc_hold=1 and squash_if_id=1 every cycle, so nothing younger than the halt enters.
  - redirect_ex in DRAIN still squashes; it aborts the drain back to RUN, because the halt was on the wrong path.
  - halt_wb → HALTED.
- HALTED/ERROR: all WEN=1, pc_hold=1, squashes 0. halted=1 or error=1 respectively. Both are sticky until RST.
- halt_wb seen in RUN (halt never observed in ID, e.g. after stall) → HALTED directly.
- Counters saturate at all-ones and never wrap. They freeze in HALTED/ERROR.
- RST assertion at any point, including mid-MEM_WAIT, immediately clears state, counters and outputs.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERROR=4, 3 bits);
  - REG_HOLD=1 / REG_WRITE=0 constants;
  - NOP instruction constant 32'h00000013.
- One sub-module is natural: hazard_detect, which is combinational lu/mw evaluation.

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back → one cycle of pc_hold=1, WEN_if_id=1, squash_id_ex=1; stall_cnt=1. The same case with rd_ex=x0 → no stall.
- Taken branch in EX while load-use also true → squash_if_id=squash_id_ex=1 for one cycle, pc_hold=0, squash_cnt=1, stall_cnt unchanged.
- Store in MEM with dmem_ready low 3 cycles → all WEN=1 and pc_hold=1 for 3 cycles, then RUN; stall_cnt=3.
- dmem_ready held low with MEM_TIMEOUT=8 → error=1 after 8 wait cycles, all WEN=1 thereafter, counters frozen.
- Halt in ID, then redirect_ex next cycle → drain aborted, RUN. Halt on the correct path → DRAIN, then halt_wb after 3 cycles → halted=1.
- RST pulsed during MEM_WAIT → outputs and counters 0 asynchronously; RUN on release.
